// File: rtl/lcd_init_pkg.sv
// Shared definitions for the LCD power-up sequencer: script entry types,
// FSM state encoding and the bit positions of the fields inside an entry.
package lcd_init_pkg;

    typedef enum logic [1:0] {
        ENT_END   = 2'b00,
        ENT_CMD   = 2'b01,
        ENT_DATA  = 2'b10,
        ENT_DELAY = 2'b11
    } entry_type_t;

    typedef enum logic [2:0] {
        IDLE,
        RST_ASSERT,
        RST_WAIT,
        FETCH,
        SHIFT,
        CS_GAP,
        DELAY,
        DONE
    } state_t;

    localparam int ENT_TYPE_HI = 9;
    localparam int ENT_TYPE_LO = 8;
    localparam int ENT_PAY_HI  = 7;
    localparam int ENT_PAY_LO  = 0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_spi9_tx.sv
// 3-wire 9-bit SPI transmitter, mode 0. Sends one word per load pulse and
// holds chip select high for SPI_DIV cycles afterwards before reporting done.
module lcd_spi9_tx #(
    parameter int SPI_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [8:0] word,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_sdo,
    output logic       frame_done
);

    localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_DIV - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_GAP
    } tx_state_t;

    tx_state_t        tx_state;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shreg;

    // Done fires in the last gap cycle so the sequencer can fetch on the next edge.
    assign frame_done = (tx_state == TX_GAP) && (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            spi_cs_n <= 1'b1;
            spi_sck  <= 1'b0;
            spi_sdo  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (load) begin
                        tx_state <= TX_SHIFT;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        shreg    <= word[7:0];
                        spi_cs_n <= 1'b0;
                        spi_sck  <= 1'b0;
                        spi_sdo  <= word[8];
                    end
                end
                TX_SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else if (bit_cnt == 4'd8) begin
                            tx_state <= TX_GAP;
                            spi_sck  <= 1'b0;
                            spi_sdo  <= 1'b0;
                            spi_cs_n <= 1'b1;
                        end else begin
                            spi_sck <= 1'b0;
                            spi_sdo <= shreg[7];
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                TX_GAP: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt  <= '0;
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_init_sequencer.sv
// Panel power-up controller: pulses the panel reset, then plays the init
// script from an external ROM over SPI and finally enables the display.
module lcd_init_sequencer
    import lcd_init_pkg::*;
#(
    parameter int SPI_DIV    = 4,
    parameter int RESET_HOLD = 100,
    parameter int RESET_WAIT = 1000,
    parameter int DELAY_UNIT = 1000,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [9:0]        rom_data,
    output logic              lcd_rst_n,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_sdo,
    output logic              busy,
    output logic              done,
    output logic              display_en
);

    localparam int CNT_W = $clog2(max3(RESET_HOLD, RESET_WAIT, 2 * SPI_DIV) + 1);
    localparam int DLY_W = $clog2(255 * DELAY_UNIT + 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(RESET_WAIT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DLY_W-1:0]  dly_cnt;
    entry_type_t       ent_type;
    logic [7:0]        ent_payload;
    logic              tx_load;
    logic              frame_done;
    logic              at_last;

    assign ent_type    = entry_type_t'(rom_data[ENT_TYPE_HI:ENT_TYPE_LO]);
    assign ent_payload = rom_data[ENT_PAY_HI:ENT_PAY_LO];
    assign at_last     = (rom_addr == ADDR_LAST);
    assign tx_load     = (state == FETCH) && ((ent_type == ENT_CMD) || (ent_type == ENT_DATA));

    lcd_spi9_tx #(
        .SPI_DIV(SPI_DIV)
    ) u_tx (
        .clk       (clk),
        .reset     (reset),
        .load      (tx_load),
        .word      ({ent_type == ENT_DATA, ent_payload}),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .spi_sdo   (spi_sdo),
        .frame_done(frame_done)
    );

    // Finishing the last address ends the script even without an END entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rom_addr   <= '0;
            cnt        <= '0;
            dly_cnt    <= '0;
            lcd_rst_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            display_en <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RST_ASSERT;
                        cnt        <= '0;
                        rom_addr   <= '0;
                        lcd_rst_n  <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        display_en <= 1'b0;
                    end
                end
                RST_ASSERT: begin
                    if (cnt == HOLD_LAST) begin
                        state     <= RST_WAIT;
                        cnt       <= '0;
                        lcd_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RST_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state    <= FETCH;
                        rom_addr <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FETCH: begin
                    case (ent_type)
                        ENT_END: begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            display_en <= 1'b1;
                        end
                        ENT_CMD, ENT_DATA: state <= SHIFT;
                        ENT_DELAY: begin
                            if (ent_payload != 8'd0) begin
                                state   <= DELAY;
                                dly_cnt <= DLY_W'(ent_payload) * DLY_W'(DELAY_UNIT) - 1'b1;
                            end else if (at_last) begin
                                state      <= DONE;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                display_en <= 1'b1;
                            end else begin
                                rom_addr <= rom_addr + 1'b1;
                            end
                        end
                        default: state <= DONE;
                    endcase
                end
                SHIFT, CS_GAP: begin
                    if (frame_done) begin
                        if (at_last) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            display_en <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            rom_addr <= rom_addr + 1'b1;
                        end
                    end else if (state == SHIFT && spi_cs_n) begin
                        state <= CS_GAP;
                    end
                end
                DELAY: begin
                    if (dly_cnt != '0) begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end else if (at_last) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        display_en <= 1'b1;
                    end else begin
                        state    <= FETCH;
                        rom_addr <= rom_addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lcd_init_sequencer.md
Name: lcd_init_sequencer

Overview:
Power-up controller for the 480x480 RGB panel driven by the display timing generator. On `start` it pulses the panel hardware reset, then streams an init script from an external ROM over 3-wire 9-bit SPI. Scripts can contain command bytes, data bytes and delays. When the script ends it asserts `display_en`, which gates the timing generator's pixel clock together with the existing GB-vsync gating.

Parameters:
SPI_DIV, 4, clk cycles per SCK half-period (>=1)
RESET_HOLD, 100, clk cycles `lcd_rst_n` is held low after start (>=1)
RESET_WAIT, 1000, clk cycles waited after `lcd_rst_n` rises, before the first ROM fetch (>=1)
DELAY_UNIT, 1000, clk cycles per delay-entry unit (>=1)
ADDR_W, 6, ROM address width; script depth is 2**ADDR_W

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins the sequence
rom_addr  out  ADDR_W  script entry index
rom_data  in  10  entry; combinational ROM, valid in the same cycle as `rom_addr`
lcd_rst_n  out  1  panel hardware reset, active-low
spi_cs_n  out  1  SPI chip select, active-low
spi_sck  out  1  SPI clock, mode 0, idles low
spi_sdo  out  1  SPI data
busy  out  1  high from start acceptance until DONE
done  out  1  high in DONE
display_en  out  1  enables the timing generator; high in DONE

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high, port `reset`.
- Reset values: `lcd_rst_n`=0, `spi_cs_n`=1, `spi_sck`=0, `spi_sdo`=0, `rom_addr`=0, `busy`=0, `done`=0, `display_en`=0. State is IDLE.
- Reset mid-operation aborts immediately to these values. No partial SPI frame completes.
- Entry format: [9:8] type, [7:0] payload.
  - 00 = END
  - 01 = CMD (D/C=0)
  - 10 = DATA (D/C=1)
  - 11 = DELAY, lasting payload*DELAY_UNIT cycles
- FSM states: IDLE, RST_ASSERT, RST_WAIT, FETCH, SHIFT, CS_GAP, DELAY, DONE.
- IDLE:
  - `lcd_rst_n` stays 0.
  - On `start` -> RST_ASSERT; `busy`=1 from the next cycle.
- RST_ASSERT: lasts RESET_HOLD cycles, `lcd_rst_n`=0, then -> RST_WAIT.
- RST_WAIT:
  - `lcd_rst_n`=1 for RESET_WAIT cycles, then -> FETCH with `rom_addr`=0.
  - `lcd_rst_n` stays 1 until the next reset or restart.
- FETCH (1 cycle) decodes `rom_data`:
  - CMD/DATA -> SHIFT
  - DELAY with payload>0 -> DELAY
  - DELAY with payload=0 -> advance address, stay in FETCH
  - END -> DONE
- SHIFT:
  - `spi_cs_n`=0 for 9 bits: D/C bit first, then payload MSB first.
  - Each bit: `spi_sdo` is set at bit start; `spi_sck` is low for SPI_DIV cycles, then high for SPI_DIV cycles.
  - Frame length is exactly 18*SPI_DIV cycles; after the last high phase, `spi_sck`=0 and `spi_sdo`=0.
  - Then -> CS_GAP.
- CS_GAP: `spi_cs_n`=1 for SPI_DIV cycles; advance `rom_addr`; -> FETCH.
- DELAY: counts payload*DELAY_UNIT cycles with no SPI activity; advance `rom_addr`; -> FETCH.
- Counter widths:
  - Delay counter: wide enough for 255*DELAY_UNIT.
  - Other counters: wide enough for max(RESET_HOLD, RESET_WAIT, 2*SPI_DIV).
- Address wrap: after executing entry 2**ADDR_W-1 (non-END), go to DONE; never wrap to 0.
- DONE: `done`=1, `display_en`=1, `busy`=0, SPI lines idle.
- `start` while `busy`: ignored.
- `start` in DONE: restart. `display_en` and `done` drop next cycle; go to RST_ASSERT.
- `start` asserted in the same cycle as `reset`: `reset` wins.

Decomposition:
- Package `lcd_init_pkg`:
  - entry type constants (ENT_END, ENT_CMD, ENT_DATA, ENT_DELAY)
  - state encoding
  - entry field positions
- Sub-module `lcd_spi9_tx`:
  - inputs: `clk`, `reset`, `load` pulse, 9-bit word, SPI_DIV
  - outputs: `spi_cs_n`, `spi_sck`, `spi_sdo`, one-cycle `frame_done`; owns SHIFT and CS_GAP timing
- Top module: FSM, reset/delay counters, address register.
- Panel script ROM: separate, outside this block.

Test Plan:
- Reset/defaults:
  - Stimulus: SPI_DIV=2, RESET_HOLD=4, RESET_WAIT=8, DELAY_UNIT=10; assert reset 3 cycles.
  - Required: all outputs at reset values; `lcd_rst_n`=0 and `busy`=0 while idle 20 cycles.
- Reset sequence and first frame:
  - Stimulus: ROM {CMD 0x11, END}; start pulse.
  - Required: `lcd_rst_n` low 4 cycles then high; `spi_cs_n` falls 9 cycles after `lcd_rst_n` rises; decoded bits 0,0x11; frame lasts 36 cycles; then `display_en`=1, `done`=1.
- Mixed script:
  - Stimulus: ROM {CMD 0xFF, DATA 0x77, DELAY 3, DATA 0x01, END}.
  - Required: captured 9-bit words 0x0FF, 0x177, 0x101; no SCK for 30 cycles during the delay; CS high ≥2 cycles between frames.
- Edge entries:
  - Stimulus: ROM {DELAY 0, CMD 0x29, END}.
  - Required: the zero delay costs 1 FETCH cycle; exactly one frame (0x029) is sent.
- No-END script:
  - Stimulus: ADDR_W=2; ROM of 4 CMD entries 0x01..0x04, no END.
  - Required: 4 frames sent, then DONE; `rom_addr` never returns to 0.
- Abort and restart:
  - Stimulus: reset mid-frame (bit 4); start again; start during `busy`; start in DONE.
  - Required: immediate idle values after reset; full clean sequence on restart; start during `busy` ignored; start in DONE drops `display_en` next cycle and reruns.
